approx_err_monitor: RTL and testbench
=====================================

// Module: approx_err_monitor
// PURPOSE
//  Receiving end of the approximate adder datapath: it consumes operand/result tuples from the
//  approximate ripple adder and computes the exact sum X+Y+Cin. It measures the error distance
//  ED=|exact-approx| and accumulates error statistics over a fixed window of WIN samples.
//  One statistics record is emitted per window over a valid/ready handshake. It sits beside the
//  adder in characterisation and BIST builds.
// PARAMETERS
//  W      8    operand width (approx result is {Cout,S}, W+1 bits)
//  WIN    256  samples per window, >=2
// PORTS
//  clk        in   1               single clock, rising edge
//  rst        in   1               synchronous, active-high reset
//  clr        in   1               sync pulse: abort window, clear accumulators, drop pending record
//  in_valid   in   1               sample valid
//  in_ready   out  1               monitor can accept a sample
//  in_x       in   W               operand X
//  in_y       in   W               operand Y
//  in_cin     in   1               carry-in
//  in_s       in   W               approx sum S
//  in_cout    in   1               approx carry-out
//  out_valid  out  1               statistics record valid
//  out_ready  in   1               consumer accepts record
//  out_errcnt out  CW              samples with ED!=0, CW=$clog2(WIN+1)
//  out_edsum  out  W+1+$clog2(WIN) sum of ED over window (sized, never overflows)
//  out_edmax  out  W+1             max ED in window
//  out_bias   out  W+2+$clog2(WIN) signed sum of (approx-exact); see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=ACCUM; in_ready=1; out_valid=0; all out_* and accumulators=0; sample count=0.
//  - Transfer happens on in_valid&in_ready (input) and on out_valid&out_ready (output).
//  - exact = {1'b0,X}+{1'b0,Y}+Cin (W+1 bits); approx = {Cout,S}; ED = unsigned |exact-approx|.
//  - FSM ACCUM: in_ready=1. Each accepted sample updates cnt, errcnt, edsum, edmax and bias.
//    When the accepted sample is number WIN, the updated totals (including that sample) are
//    latched into out_*. The accumulators and cnt are cleared, and the FSM goes to REPORT.
//  - FSM REPORT: out_valid=1, in_ready=0 (back-pressure). On out_ready the FSM returns to ACCUM,
//    out_valid drops the next cycle, and out_* hold their last values.
//  - Latency: out_valid rises on the cycle after the clock edge that accepted sample WIN.
//    Throughput: WIN samples per WIN+1 cycles minimum.
//  - out_* are stable while out_valid=1 and out_ready=0.
//  - clr has priority over every other event, including a same-cycle input or output transfer.
//    A sample presented with clr is dropped. clr goes to ACCUM, clears cnt and the accumulators,
//    and sets out_valid=0; out_* are zeroed.
//  - rst mid-window or mid-REPORT: identical to the reset state; no record is emitted.
//  - edmax compare is unsigned >=; a window with no errors reports 0/0/0.
// CONFIGURATION
//  APPROX_ERR_BIAS_EN defined: out_bias accumulates signed (approx-exact) per window and is
//    latched, held and cleared exactly like out_edsum.
//  APPROX_ERR_BIAS_EN undefined: the bias accumulator is not built and out_bias is tied to 0.
//    The port is always present.
// STRUCTURE
//  - approx_pkg: FSM state encodings (ST_ACCUM, ST_REPORT) and width helper constants
//    (CW, SUMW, BIASW derived from W and WIN), shared with the adder testbenches.
//  - Sub-module approx_err_calc: combinational; inputs x, y, cin, s, cout; outputs exact, ed,
//    err (ed!=0) and signed diff. The top module holds the FSM, counter and accumulators.
// TESTING (W=8, WIN=4 unless noted)
//  1 Four samples X=0x01,Y=0x00,Cin=1,S=0x03,Cout=0 (exact 2, approx 3)
//    -> errcnt=4, edsum=4, edmax=1, bias=+4 (0 without APPROX_ERR_BIAS_EN).
//  2 Four exact samples X=0x0F,Y=0x01,Cin=0,S=0x10,Cout=0
//    -> record 0/0/0; out_valid exactly 1 cycle after the 4th accept.
//  3 Window with EDs 1,0,7,2 -> errcnt=3, edsum=10, edmax=7.
//    Hold out_ready=0 for 5 cycles -> in_ready=0, out_* stable; then out_ready=1 -> ACCUM.
//  4 clr asserted with the 3rd valid sample -> sample dropped. The next 4 samples form a fresh
//    window, and the record reflects only those 4.
//  5 rst asserted in REPORT -> out_valid=0, in_ready=1, out_*=0 the next cycle.
//  6 W=8, WIN=256, every sample ED=511 (X=Y=0xFF,Cin=1,S=0,Cout=0)
//    -> edsum=130816, edmax=511, no overflow.

Source files
------------

// File: rtl/approx_pkg.sv
// Shared encodings and width helpers for the approximate adder error monitor.
package approx_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_REPORT = 1'b1
    } state_t;

    // Default datapath geometry.
    localparam int unsigned W_DEF   = 8;
    localparam int unsigned WIN_DEF = 256;

    // Error-count width: must hold the value WIN itself.
    function automatic int unsigned calc_cw(input int unsigned win);
        return $clog2(win + 1);
    endfunction

    // ED-sum width: WIN samples of up to 2^(W+1)-1 each.
    function automatic int unsigned calc_sumw(input int unsigned w, input int unsigned win);
        return w + 1 + $clog2(win);
    endfunction

    // Signed bias width: one sign bit above the ED-sum width.
    function automatic int unsigned calc_biasw(input int unsigned w, input int unsigned win);
        return w + 2 + $clog2(win);
    endfunction

    localparam int unsigned CW    = calc_cw(WIN_DEF);
    localparam int unsigned SUMW  = calc_sumw(W_DEF, WIN_DEF);
    localparam int unsigned BIASW = calc_biasw(W_DEF, WIN_DEF);

endpackage

// File: rtl/approx_err_calc.sv
// Combinational error evaluation of one approximate-adder sample.
module approx_err_calc
    import approx_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic               i_x_unused_guard,
    input  logic [W-1:0]       i_x,
    input  logic [W-1:0]       i_y,
    input  logic               i_cin,
    input  logic [W-1:0]       i_s,
    input  logic               i_cout,
    output logic [W:0]         o_exact,
    output logic [W:0]         o_ed,
    output logic               o_err,
    output logic signed [W+1:0] o_diff
);

    logic [W:0] w_approx;
    logic       w_unused_guard;

    assign w_unused_guard = i_x_unused_guard;
    assign w_approx = {i_cout, i_s};
    assign o_exact  = {1'b0, i_x} + {1'b0, i_y} + (W+1)'(i_cin);
    // One extra bit so approx-exact never wraps.
    assign o_diff   = $signed({1'b0, w_approx}) - $signed({1'b0, o_exact});
    assign o_ed     = o_diff[W+1] ? (W+1)'(-o_diff) : o_diff[W:0];
    assign o_err    = |o_ed;

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error-statistics monitor for the approximate ripple adder.
// Optional macro APPROX_ERR_BIAS_EN builds the signed bias accumulator;
// without it out_bias is tied to zero.
module approx_err_monitor
    import approx_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned WIN = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [W-1:0]                    in_x,
    input  logic [W-1:0]                    in_y,
    input  logic                            in_cin,
    input  logic [W-1:0]                    in_s,
    input  logic                            in_cout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [calc_cw(WIN)-1:0]         out_errcnt,
    output logic [calc_sumw(W, WIN)-1:0]    out_edsum,
    output logic [W:0]                      out_edmax,
    output logic [calc_biasw(W, WIN)-1:0]   out_bias
);

    localparam int unsigned ERRCNT_W = calc_cw(WIN);
    localparam int unsigned EDSUM_W  = calc_sumw(W, WIN);
    localparam int unsigned BIAS_W   = calc_biasw(W, WIN);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [ERRCNT_W-1:0]    r_cnt;
    logic [ERRCNT_W-1:0]    r_errcnt;
    logic [EDSUM_W-1:0]     r_edsum;
    logic [W:0]             r_edmax;
    logic [ERRCNT_W-1:0]    r_out_errcnt;
    logic [EDSUM_W-1:0]     r_out_edsum;
    logic [W:0]             r_out_edmax;

    logic [W:0]             w_exact;
    logic [W:0]             w_ed;
    logic                   w_err;
    logic signed [W+1:0]    w_diff;
    logic                   w_in_fire;
    logic                   w_last;
    logic [ERRCNT_W-1:0]    w_errcnt_upd;
    logic [EDSUM_W-1:0]     w_edsum_upd;
    logic [W:0]             w_edmax_upd;

    approx_err_calc #(.W(W)) u_calc (
        .i_x_unused_guard (1'b0),
        .i_x              (in_x),
        .i_y              (in_y),
        .i_cin            (in_cin),
        .i_s              (in_s),
        .i_cout           (in_cout),
        .o_exact          (w_exact),
        .o_ed             (w_ed),
        .o_err            (w_err),
        .o_diff           (w_diff)
    );

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_errcnt   = r_out_errcnt;
    assign out_edsum    = r_out_edsum;
    assign out_edmax    = r_out_edmax;

    assign w_in_fire    = in_valid & r_in_ready;
    assign w_last       = w_in_fire && (r_cnt == ERRCNT_W'(WIN - 1));
    assign w_errcnt_upd = r_errcnt + ERRCNT_W'(w_err);
    assign w_edsum_upd  = r_edsum + EDSUM_W'(w_ed);
    assign w_edmax_upd  = (w_ed >= r_edmax) ? w_ed : r_edmax;

    // Next-state: window completion enters REPORT, consumer accept leaves it, clr wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM:  if (w_last)    w_state_nxt = ST_REPORT;
            ST_REPORT: if (out_ready) w_state_nxt = ST_ACCUM;
            default:                  w_state_nxt = ST_ACCUM;
        endcase
        if (clr) w_state_nxt = ST_ACCUM;
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_ACCUM);
            r_out_valid <= (w_state_nxt == ST_REPORT);
        end
    end

    // Accumulators and record latch; the last sample of a window lands in the record.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt        <= '0;
            r_errcnt     <= '0;
            r_edsum      <= '0;
            r_edmax      <= '0;
            r_out_errcnt <= '0;
            r_out_edsum  <= '0;
            r_out_edmax  <= '0;
        end else if (w_in_fire) begin
            if (w_last) begin
                r_out_errcnt <= w_errcnt_upd;
                r_out_edsum  <= w_edsum_upd;
                r_out_edmax  <= w_edmax_upd;
                r_cnt        <= '0;
                r_errcnt     <= '0;
                r_edsum      <= '0;
                r_edmax      <= '0;
            end else begin
                r_cnt        <= r_cnt + ERRCNT_W'(1);
                r_errcnt     <= w_errcnt_upd;
                r_edsum      <= w_edsum_upd;
                r_edmax      <= w_edmax_upd;
            end
        end
    end

`ifdef APPROX_ERR_BIAS_EN
    logic signed [BIAS_W-1:0] r_bias;
    logic signed [BIAS_W-1:0] r_out_bias;
    logic signed [BIAS_W-1:0] w_bias_upd;
    logic                     w_unused_calc;

    assign w_bias_upd    = r_bias + BIAS_W'(w_diff);
    assign out_bias      = r_out_bias;
    assign w_unused_calc = ^w_exact;

    // Signed bias accumulator, cleared and latched alongside the ED sum.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_bias     <= '0;
            r_out_bias <= '0;
        end else if (w_in_fire) begin
            if (w_last) begin
                r_out_bias <= w_bias_upd;
                r_bias     <= '0;
            end else begin
                r_bias     <= w_bias_upd;
            end
        end
    end
`else
    logic w_unused_calc;

    assign out_bias      = '0;
    assign w_unused_calc = ^{w_exact, w_diff};
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor: WIN=4 instance for directed windows,
// WIN=256 instance for the full-scale no-overflow window.
module tb_approx_err_monitor;
    import approx_pkg::*;

    localparam int unsigned W      = 8;
    localparam int unsigned WIN_A  = 4;
    localparam int unsigned WIN_B  = 256;
    localparam int unsigned CW_A   = calc_cw(WIN_A);
    localparam int unsigned SW_A   = calc_sumw(W, WIN_A);
    localparam int unsigned BW_A   = calc_biasw(W, WIN_A);
    localparam int unsigned CW_B   = calc_cw(WIN_B);
    localparam int unsigned SW_B   = calc_sumw(W, WIN_B);
    localparam int unsigned BW_B   = calc_biasw(W, WIN_B);

    typedef struct {
        longint errcnt;
        longint edsum;
        longint edmax;
        longint bias;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            a_rst = 1'b1, a_clr = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
    logic [W-1:0]    a_in_x = '0, a_in_y = '0, a_in_s = '0;
    logic            a_in_cin = 1'b0, a_in_cout = 1'b0;
    logic            a_in_ready, a_out_valid;
    logic [CW_A-1:0] a_out_errcnt;
    logic [SW_A-1:0] a_out_edsum;
    logic [W:0]      a_out_edmax;
    logic [BW_A-1:0] a_out_bias;

    logic            b_rst = 1'b1, b_clr = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
    logic [W-1:0]    b_in_x = '0, b_in_y = '0, b_in_s = '0;
    logic            b_in_cin = 1'b0, b_in_cout = 1'b0;
    logic            b_in_ready, b_out_valid;
    logic [CW_B-1:0] b_out_errcnt;
    logic [SW_B-1:0] b_out_edsum;
    logic [W:0]      b_out_edmax;
    logic [BW_B-1:0] b_out_bias;

    approx_err_monitor #(.W(W), .WIN(WIN_A)) u_dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y), .in_cin(a_in_cin), .in_s(a_in_s), .in_cout(a_in_cout),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_errcnt(a_out_errcnt), .out_edsum(a_out_edsum),
        .out_edmax(a_out_edmax), .out_bias(a_out_bias)
    );

    approx_err_monitor #(.W(W), .WIN(WIN_B)) u_dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y), .in_cin(b_in_cin), .in_s(b_in_s), .in_cout(b_in_cout),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_errcnt(b_out_errcnt), .out_edsum(b_out_edsum),
        .out_edmax(b_out_edmax), .out_bias(b_out_bias)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    rec_t q_a[$];
    rec_t q_b[$];
    rec_t e_a, e_b;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic longint exp_bias(input longint v);
`ifdef APPROX_ERR_BIAS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic rec_t mk(input longint c, input longint s, input longint m, input longint b);
        rec_t r;
        r.errcnt = c; r.edsum = s; r.edmax = m; r.bias = exp_bias(b);
        return r;
    endfunction

    // Record monitor for the WIN=4 instance.
    initial forever begin
        @(negedge clk);
        if (!a_rst && a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_record", longint'(a_out_valid), 0);
            end else begin
                e_a = q_a.pop_front();
                chk("a_errcnt", longint'(a_out_errcnt), e_a.errcnt);
                chk("a_edsum",  longint'(a_out_edsum),  e_a.edsum);
                chk("a_edmax",  longint'(a_out_edmax),  e_a.edmax);
                chk("a_bias",   longint'($signed(a_out_bias)), e_a.bias);
            end
        end
    end

    // Record monitor for the WIN=256 instance.
    initial forever begin
        @(negedge clk);
        if (!b_rst && b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_record", longint'(b_out_valid), 0);
            end else begin
                e_b = q_b.pop_front();
                chk("b_errcnt", longint'(b_out_errcnt), e_b.errcnt);
                chk("b_edsum",  longint'(b_out_edsum),  e_b.edsum);
                chk("b_edmax",  longint'(b_out_edmax),  e_b.edmax);
                chk("b_bias",   longint'($signed(b_out_bias)), e_b.bias);
            end
        end
    end

    // Offer one sample to instance A; returns one cycle after it is accepted.
    task automatic send_a(input logic [7:0] x, input logic [7:0] y, input logic cin,
                          input logic [7:0] s, input logic cout);
        int n;
        a_in_x = x; a_in_y = y; a_in_cin = cin; a_in_s = s; a_in_cout = cout;
        a_in_valid = 1'b1;
        n = 0;
        while (!a_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("a_in_ready_wait", longint'(a_in_ready), 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] x, input logic [7:0] y, input logic cin,
                          input logic [7:0] s, input logic cout);
        int n;
        b_in_x = x; b_in_y = y; b_in_cin = cin; b_in_s = s; b_in_cout = cout;
        b_in_valid = 1'b1;
        n = 0;
        while (!b_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("b_in_ready_wait", longint'(b_in_ready), 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); @(posedge clk); #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  longint'(a_in_ready), 1);
        chk("rst_out_valid", longint'(a_out_valid), 0);
        chk("rst_errcnt",    longint'(a_out_errcnt), 0);
        chk("rst_edsum",     longint'(a_out_edsum), 0);
        chk("rst_edmax",     longint'(a_out_edmax), 0);
        chk("rst_bias",      longint'($signed(a_out_bias)), 0);

        // 1: constant ED=1, approx above exact
        q_a.push_back(mk(4, 4, 1, 4));
        repeat (4) send_a(8'h01, 8'h00, 1'b1, 8'h03, 1'b0);
        chk("t1_out_valid", longint'(a_out_valid), 1);
        @(posedge clk); #1;
        chk("t1_valid_drop", longint'(a_out_valid), 0);
        chk("t1_in_ready",   longint'(a_in_ready), 1);

        // 2: exact window, latency of out_valid
        q_a.push_back(mk(0, 0, 0, 0));
        repeat (3) send_a(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        chk("t2_valid_early", longint'(a_out_valid), 0);
        send_a(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        chk("t2_latency", longint'(a_out_valid), 1);
        @(posedge clk); #1;

        // 3: EDs 1,0,7,2 with back-pressure
        q_a.push_back(mk(3, 10, 7, -4));
        send_a(8'h00, 8'h00, 1'b0, 8'h01, 1'b0);
        send_a(8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
        send_a(8'h10, 8'h00, 1'b0, 8'h09, 1'b0);
        a_out_ready = 1'b0;
        send_a(8'h20, 8'h20, 1'b1, 8'h43, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_in_ready",  longint'(a_in_ready), 0);
            chk("t3_hold_out_valid", longint'(a_out_valid), 1);
            chk("t3_hold_errcnt",    longint'(a_out_errcnt), 3);
            chk("t3_hold_edsum",     longint'(a_out_edsum), 10);
            chk("t3_hold_edmax",     longint'(a_out_edmax), 7);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3_release_valid", longint'(a_out_valid), 0);
        chk("t3_release_ready", longint'(a_in_ready), 1);
        chk("t3_out_held",      longint'(a_out_edsum), 10);

        // 4: clr with the 3rd sample
        q_a.push_back(mk(4, 8, 2, 8));
        send_a(8'h01, 8'h00, 1'b1, 8'h03, 1'b0);
        send_a(8'h01, 8'h00, 1'b1, 8'h03, 1'b0);
        a_in_x = 8'h10; a_in_y = 8'h00; a_in_cin = 1'b0; a_in_s = 8'h09; a_in_cout = 1'b0;
        a_in_valid = 1'b1;
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_clr = 1'b0;
        chk("t4_clr_valid",  longint'(a_out_valid), 0);
        chk("t4_clr_errcnt", longint'(a_out_errcnt), 0);
        chk("t4_clr_edsum",  longint'(a_out_edsum), 0);
        chk("t4_clr_edmax",  longint'(a_out_edmax), 0);
        repeat (4) send_a(8'h20, 8'h20, 1'b1, 8'h43, 1'b0);
        @(posedge clk); #1;

        // 5: rst while in REPORT drops the record
        a_out_ready = 1'b0;
        repeat (4) send_a(8'h01, 8'h00, 1'b1, 8'h03, 1'b0);
        chk("t5_report", longint'(a_out_valid), 1);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        chk("t5_valid",  longint'(a_out_valid), 0);
        chk("t5_ready",  longint'(a_in_ready), 1);
        chk("t5_errcnt", longint'(a_out_errcnt), 0);
        chk("t5_edsum",  longint'(a_out_edsum), 0);
        chk("t5_edmax",  longint'(a_out_edmax), 0);
        chk("t5_bias",   longint'($signed(a_out_bias)), 0);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_record", longint'(a_out_valid), 0);

        // 6: full-scale window, ED=511 every sample
        q_b.push_back(mk(256, 130816, 511, -130816));
        repeat (255) send_b(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
        chk("t6_valid_early", longint'(b_out_valid), 0);
        send_b(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);
        chk("t6_latency", longint'(b_out_valid), 1);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", longint'(q_a.size()), 0);
        chk("b_queue_drained", longint'(q_b.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
